// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces sync, blank, physical and down-scaled coordinates, line/frame
// strobes and a frame counter, all registered so they describe the current
// raster position.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 0,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic             HS,
  output logic             VS,
  output logic             blank,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic [CNT_W-1:0] x_log,
  output logic [CNT_W-1:0] y_log,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic [7:0]       frame_cnt_nxt;
  logic             line_start_nxt;
  logic             frame_start_nxt;
  logic             hs_act;
  logic             vs_act;

  // Next raster position; counters wrap with equality compares so they can
  // never run past the last pixel/line, and strobes only fire on an enabled
  // wrap so they stay one clock wide.
  always_comb begin
    x_nxt           = x;
    y_nxt           = y;
    frame_cnt_nxt   = frame_cnt;
    line_start_nxt  = 1'b0;
    frame_start_nxt = 1'b0;
    if (pix_en) begin
      if (x == H_LAST) begin
        x_nxt          = '0;
        line_start_nxt = 1'b1;
        if (y == V_LAST) begin
          y_nxt           = '0;
          frame_start_nxt = 1'b1;
          frame_cnt_nxt   = frame_cnt + 8'd1;
        end else begin
          y_nxt = y + 1'b1;
        end
      end else begin
        x_nxt = x + 1'b1;
      end
    end
  end

  // Sync windows decoded from the next position so the registered syncs line
  // up with the registered coordinates.
  always_comb begin
    hs_act = (x_nxt >= HS_START) && (x_nxt < HS_END);
    vs_act = (y_nxt >= VS_START) && (y_nxt < VS_END);
  end

  // Register counters and every decoded output on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      x_log       <= '0;
      y_log       <= '0;
      blank       <= 1'b0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      x           <= x_nxt;
      y           <= y_nxt;
      x_log       <= x_nxt >> SCALE_SHIFT;
      y_log       <= y_nxt >> SCALE_SHIFT;
      blank       <= (x_nxt >= H_VIS) || (y_nxt >= V_VIS);
      HS          <= hs_act ? HS_POL : ~HS_POL;
      VS          <= vs_act ? VS_POL : ~VS_POL;
      line_start  <= line_start_nxt;
      frame_start <= frame_start_nxt;
      frame_cnt   <= frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two timing generators driven side by side. dut0 uses the
// stock 640x480@60 timing; dut1 keeps the horizontal timing but has an
// 8-line frame, positive HS and a 2x down-scale so frame wrap is reachable.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic pix_en;

  always #5 clk = ~clk;

  logic       d0_hs, d0_vs, d0_blank, d0_ls, d0_fs;
  logic [9:0] d0_x, d0_y, d0_xl, d0_yl;
  logic [7:0] d0_fc;
  logic       d1_hs, d1_vs, d1_blank, d1_ls, d1_fs;
  logic [9:0] d1_x, d1_y, d1_xl, d1_yl;
  logic [7:0] d1_fc;

  vga_timing_gen dut0 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .HS(d0_hs), .VS(d0_vs), .blank(d0_blank),
    .x(d0_x), .y(d0_y), .x_log(d0_xl), .y_log(d0_yl),
    .line_start(d0_ls), .frame_start(d0_fs), .frame_cnt(d0_fc)
  );

  vga_timing_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .SCALE_SHIFT(1), .CNT_W(10)
  ) dut1 (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .HS(d1_hs), .VS(d1_vs), .blank(d1_blank),
    .x(d1_x), .y(d1_y), .x_log(d1_xl), .y_log(d1_yl),
    .line_start(d1_ls), .frame_start(d1_fs), .frame_cnt(d1_fc)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] xl;
    logic [9:0] yl;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  obs_t q0[$];
  obs_t q1[$];

  int nCompared   = 0;
  int nMismatched = 0;

  // reference raster model, one slot per DUT
  int mx[2];
  int my[2];
  int mfc[2];
  bit mls[2];
  bit mfs[2];

  // window tallies taken from observed outputs
  bit tally = 1'b0;
  int hsLow0, lsCnt0, lsPair0, vsLow1, fsCnt1;
  bit prevLs0;

  function automatic int vTotal(input int id);
    return (id == 0) ? 525 : 8;
  endfunction

  function automatic obs_t expectFor(input int id);
    obs_t e;
    int   va  = (id == 0) ? 480 : 4;
    int   vf  = (id == 0) ? 10 : 1;
    bit   hp  = (id == 1);
    int   sh  = (id == 1) ? 1 : 0;
    e.hs    = (mx[id] >= 656 && mx[id] < 752) ? hp : !hp;
    e.vs    = (my[id] >= va + vf && my[id] < va + vf + 2) ? 1'b0 : 1'b1;
    e.blank = (mx[id] >= 640) || (my[id] >= va);
    e.x     = 10'(mx[id]);
    e.y     = 10'(my[id]);
    e.xl    = 10'(mx[id] >> sh);
    e.yl    = 10'(my[id] >> sh);
    e.ls    = mls[id];
    e.fs    = mfs[id];
    e.fc    = 8'(mfc[id]);
    return e;
  endfunction

  // drive inputs, advance the model and queue what each DUT must show next
  task automatic applyStimulus(input bit r, input bit en);
    reset  = r;
    pix_en = en;
    for (int d = 0; d < 2; d++) begin
      mls[d] = 1'b0;
      mfs[d] = 1'b0;
      if (!r) begin
        mx[d]  = 0;
        my[d]  = 0;
        mfc[d] = 0;
      end else if (en) begin
        if (mx[d] == 799) begin
          mx[d]  = 0;
          mls[d] = 1'b1;
          if (my[d] == vTotal(d) - 1) begin
            my[d]  = 0;
            mfs[d] = 1'b1;
            mfc[d] = (mfc[d] + 1) % 256;
          end else begin
            my[d] = my[d] + 1;
          end
        end else begin
          mx[d] = mx[d] + 1;
        end
      end
    end
    q0.push_back(expectFor(0));
    q1.push_back(expectFor(1));
  endtask

  task automatic checkEq(input string tag, input int observed, input int expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // pop the scoreboard and compare against what the DUTs present now
  task automatic checkOutput();
    obs_t o0, o1, e0, e1;
    o0 = {d0_hs, d0_vs, d0_blank, d0_x, d0_y, d0_xl, d0_yl, d0_ls, d0_fs, d0_fc};
    o1 = {d1_hs, d1_vs, d1_blank, d1_x, d1_y, d1_xl, d1_yl, d1_ls, d1_fs, d1_fc};
    checkEq("scoreboard_depth", q0.size() + q1.size(), 2);
    if (q0.size() > 0 && q1.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      nCompared++;
      assert (o0 === e0) else begin
        nMismatched++;
        $error("[TB] FAIL dut0_outputs t=%0t observed=%h expected=%h", $time, o0, e0);
      end
      nCompared++;
      assert (o1 === e1) else begin
        nMismatched++;
        $error("[TB] FAIL dut1_outputs t=%0t observed=%h expected=%h", $time, o1, e1);
      end
    end
    if (tally) begin
      if (d0_hs === 1'b0) hsLow0++;
      if (d0_ls === 1'b1) lsCnt0++;
      if (d0_ls === 1'b1 && prevLs0) lsPair0++;
      if (d1_vs === 1'b0) vsLow1++;
      if (d1_fs === 1'b1) fsCnt1++;
    end
    prevLs0 = (d0_ls === 1'b1);
  endtask

  task automatic step(input bit r, input bit en);
    applyStimulus(r, en);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic clearTally();
    hsLow0  = 0;
    lsCnt0  = 0;
    lsPair0 = 0;
    vsLow1  = 0;
    fsCnt1  = 0;
  endtask

  initial begin
    prevLs0 = 1'b0;
    clearTally();

    // reset held with pix_en high
    repeat (3) step(1'b0, 1'b1);
    checkEq("reset_x", int'(d0_x), 0);
    checkEq("reset_hs_idle", int'(d0_hs), 1);
    checkEq("reset_vs_idle", int'(d0_vs), 1);

    // one full line at default timing
    $display("[TB] one line, pix_en=1");
    tally = 1'b1;
    repeat (800) step(1'b1, 1'b1);
    tally = 1'b0;
    checkEq("line_hs_low_clks", hsLow0, 96);
    checkEq("line_start_count", lsCnt0, 1);
    checkEq("line_wrap_y", int'(d0_y), 1);

    // pix_en alternating: line period doubles, strobes stay one clock
    $display("[TB] pix_en toggling");
    clearTally();
    tally = 1'b1;
    repeat (800) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
    end
    tally = 1'b0;
    checkEq("toggle_line_start_count", lsCnt0, 1);
    checkEq("toggle_strobe_width", lsPair0, 0);
    checkEq("toggle_y", int'(d0_y), 2);

    // run long enough for dut1 to complete a frame
    $display("[TB] frame wrap on short-frame instance");
    clearTally();
    tally = 1'b1;
    repeat (6400) step(1'b1, 1'b1);
    tally = 1'b0;
    checkEq("frame_start_count", fsCnt1, 1);
    checkEq("frame_vs_low_clks", vsLow1, 1600);
    checkEq("frame_cnt_after_wrap", int'(d1_fc), 1);

    // mid-frame reset
    $display("[TB] mid-frame reset");
    repeat (300) step(1'b1, 1'b1);
    checkEq("pre_reset_x", int'(d0_x), 300);
    step(1'b0, 1'b1);
    checkEq("mid_reset_x", int'(d0_x), 0);
    checkEq("mid_reset_frame_cnt", int'(d1_fc), 0);
    checkEq("mid_reset_no_frame_start", int'(d1_fs), 0);
    repeat (5) step(1'b1, 1'b1);
    checkEq("post_reset_x", int'(d0_x), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
